// File: rtl/vend_fsm_param_if.sv
// Coin/dispense/change handshake bundle between the front end (master) and the vending FSM (slave).
// VEND_PRICE_PROG_EN adds the price-programming port pair.
interface vend_fsm_param_if #(
  parameter int CREDIT_W = 8
);
  logic                nickel;
  logic                dime;
  logic                quarter;
  logic                cancel;
  logic                vend_ack;
  logic                change_ack;
  logic                open;
  logic                change_valid;
  logic                coin_reject;
  logic [CREDIT_W-1:0] change_amt;
  logic [CREDIT_W-1:0] credit;
`ifdef VEND_PRICE_PROG_EN
  logic                price_wr;
  logic [CREDIT_W-1:0] price_in;
`endif

  modport master (
    output nickel, dime, quarter, cancel, vend_ack, change_ack,
`ifdef VEND_PRICE_PROG_EN
    output price_wr, price_in,
`endif
    input  open, change_valid, coin_reject, change_amt, credit
  );

  modport slave (
    input  nickel, dime, quarter, cancel, vend_ack, change_ack,
`ifdef VEND_PRICE_PROG_EN
    input  price_wr, price_in,
`endif
    output open, change_valid, coin_reject, change_amt, credit
  );
endinterface

// File: rtl/vend_fsm_param.sv
// Coin-accumulating vending FSM: holds open until vend_ack, change/refund until change_ack; all outputs registered.
// VEND_PRICE_PROG_EN adds a runtime price register writable only while idle with zero credit.
module vend_fsm_param #(
  parameter int PRICE       = 15,
  parameter int NICKEL_VAL  = 5,
  parameter int DIME_VAL    = 10,
  parameter int QUARTER_VAL = 25,
  parameter int CREDIT_W    = 8
) (
  input logic            clk,
  input logic            reset_n,
  vend_fsm_param_if.slave bus
);
  localparam int MAX_COIN = (QUARTER_VAL > DIME_VAL) ?
                            ((QUARTER_VAL > NICKEL_VAL) ? QUARTER_VAL : NICKEL_VAL) :
                            ((DIME_VAL > NICKEL_VAL) ? DIME_VAL : NICKEL_VAL);

  generate
    if (PRICE <= 0) begin : g_bad_price
      $error("vend_fsm_param: PRICE must be > 0");
    end
    if ((longint'(1) << CREDIT_W) <= longint'(PRICE - 1 + MAX_COIN)) begin : g_bad_width
      $error("vend_fsm_param: CREDIT_W too narrow for PRICE and coin values");
    end
  endgenerate

  typedef enum logic [1:0] {
    ACCUM    = 2'd0,
    DISPENSE = 2'd1,
    RETURN   = 2'd2
  } state_t;

  state_t              state;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] change_amt_q;
  logic                open_q;
  logic                change_valid_q;
  logic                coin_reject_q;
  logic [CREDIT_W-1:0] price;

  logic                any_coin;
  logic                multi_coin;
  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   sum;

  always_comb begin
    any_coin   = bus.nickel | bus.dime | bus.quarter;
    multi_coin = (bus.nickel & bus.dime) | (bus.nickel & bus.quarter) | (bus.dime & bus.quarter);
    coin_val   = '0;
    if (bus.nickel)       coin_val = (CREDIT_W+1)'(NICKEL_VAL);
    else if (bus.dime)    coin_val = (CREDIT_W+1)'(DIME_VAL);
    else if (bus.quarter) coin_val = (CREDIT_W+1)'(QUARTER_VAL);
    // One bit wider so a large programmed price cannot make the compare wrap.
    sum = {1'b0, credit_q} + coin_val;
  end

`ifdef VEND_PRICE_PROG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      price <= CREDIT_W'(PRICE);
    end else if (bus.price_wr && (state == ACCUM) && (credit_q == '0) && (bus.price_in != '0)) begin
      price <= bus.price_in;
    end
  end
`else
  assign price = CREDIT_W'(PRICE);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ACCUM;
      credit_q       <= '0;
      change_amt_q   <= '0;
      open_q         <= 1'b0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
    end else begin
      coin_reject_q <= 1'b0;
      case (state)
        ACCUM: begin
          if (bus.cancel) begin
            coin_reject_q <= any_coin;
            if (credit_q != '0) begin
              change_amt_q   <= credit_q;
              change_valid_q <= 1'b1;
              state          <= RETURN;
            end
          end else if (multi_coin) begin
            coin_reject_q <= 1'b1;
          end else if (any_coin) begin
            if (sum >= {1'b0, price}) begin
              credit_q <= CREDIT_W'(sum - {1'b0, price});
              open_q   <= 1'b1;
              state    <= DISPENSE;
            end else begin
              credit_q <= CREDIT_W'(sum);
            end
          end
        end
        DISPENSE: begin
          coin_reject_q <= any_coin;
          if (bus.vend_ack) begin
            open_q <= 1'b0;
            if (credit_q != '0) begin
              change_amt_q   <= credit_q;
              change_valid_q <= 1'b1;
              state          <= RETURN;
            end else begin
              state <= ACCUM;
            end
          end
        end
        RETURN: begin
          coin_reject_q <= any_coin;
          if (bus.change_ack) begin
            credit_q       <= '0;
            change_amt_q   <= '0;
            change_valid_q <= 1'b0;
            state          <= ACCUM;
          end
        end
        default: begin
          state          <= ACCUM;
          open_q         <= 1'b0;
          change_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.open         = open_q;
  assign bus.change_valid = change_valid_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.change_amt   = change_amt_q;
  assign bus.credit       = credit_q;
endmodule

// File: tb/tb_vend_fsm_param.sv
// Scoreboarded bench for vend_fsm_param at default parameters; price-programming steps run when VEND_PRICE_PROG_EN is defined.
module tb_vend_fsm_param;
  typedef struct packed {
    logic       open;
    logic       cv;
    logic [7:0] amt;
    logic       rej;
    logic [7:0] credit;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  vend_fsm_param_if #(.CREDIT_W(8)) bus ();

  vend_fsm_param #(
    .PRICE(15), .NICKEL_VAL(5), .DIME_VAL(10), .QUARTER_VAL(25), .CREDIT_W(8)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    check({tag, ".open"},   32'(bus.open),         32'(e.open));
    check({tag, ".cv"},     32'(bus.change_valid), 32'(e.cv));
    check({tag, ".amt"},    32'(bus.change_amt),   32'(e.amt));
    check({tag, ".rej"},    32'(bus.coin_reject),  32'(e.rej));
    check({tag, ".credit"}, 32'(bus.credit),       32'(e.credit));
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then pop and compare.
  task automatic step(input string tag, input logic n, input logic d, input logic q,
                      input logic c, input logic va, input logic ca,
                      input logic e_open, input logic e_cv, input logic [7:0] e_amt,
                      input logic e_rej, input logic [7:0] e_cr);
    exp_t e;
    bus.nickel = n; bus.dime = d; bus.quarter = q;
    bus.cancel = c; bus.vend_ack = va; bus.change_ack = ca;
    e = '{open: e_open, cv: e_cv, amt: e_amt, rej: e_rej, credit: e_cr};
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    bus.nickel = 0; bus.dime = 0; bus.quarter = 0;
    bus.cancel = 0; bus.vend_ack = 0; bus.change_ack = 0;
`ifdef VEND_PRICE_PROG_EN
    bus.price_wr = 0;
`endif
    if (exp_q.size() == 0) check("sb_empty", 32'd0, 32'd1);
    else check_outs(tag_q.pop_front(), exp_q.pop_front());
  endtask

`ifdef VEND_PRICE_PROG_EN
  task automatic price_write(input string tag, input logic [7:0] val,
                             input logic [7:0] e_cr);
    bus.price_wr = 1'b1;
    bus.price_in = val;
    step(tag, 0,0,0, 0,0,0, 0,0,8'd0,0,e_cr);
  endtask
`endif

  initial begin
    bus.nickel = 0; bus.dime = 0; bus.quarter = 0;
    bus.cancel = 0; bus.vend_ack = 0; bus.change_ack = 0;
`ifdef VEND_PRICE_PROG_EN
    bus.price_wr = 0; bus.price_in = '0;
`endif
    #2;
    check_outs("reset", '{open: 0, cv: 0, amt: 0, rej: 0, credit: 0});
    #10 reset_n = 1'b1;

    //    tag          n d q  c va ca  open cv amt  rej credit
    step("dime",       0,1,0, 0,0,0,   0,0,8'd0, 0,8'd10);
    step("nickel_buy", 1,0,0, 0,0,0,   1,0,8'd0, 0,8'd0);
    step("hold_open",  0,0,0, 0,0,0,   1,0,8'd0, 0,8'd0);
    step("vack_exact", 0,0,0, 0,1,0,   0,0,8'd0, 0,8'd0);
    step("idle_nocv",  0,0,0, 0,0,0,   0,0,8'd0, 0,8'd0);

    step("quarter",    0,0,1, 0,0,0,   1,0,8'd0, 0,8'd10);
    step("vack_chg",   0,0,0, 0,1,0,   0,1,8'd10,0,8'd10);
    step("hold_chg",   0,0,0, 0,0,0,   0,1,8'd10,0,8'd10);
    step("cack",       0,0,0, 0,0,1,   0,0,8'd0, 0,8'd0);

    step("nickel5",    1,0,0, 0,0,0,   0,0,8'd0, 0,8'd5);
    step("cancel5",    0,0,0, 1,0,0,   0,1,8'd5, 0,8'd5);
    step("cack5",      0,0,0, 0,0,1,   0,0,8'd0, 0,8'd0);
    step("nickel5b",   1,0,0, 0,0,0,   0,0,8'd0, 0,8'd5);
    step("dime_cancel",0,1,0, 1,0,0,   0,1,8'd5, 1,8'd5);
    step("cack5b",     0,0,0, 0,0,1,   0,0,8'd0, 0,8'd0);
    step("cancel_zero",0,0,0, 1,0,0,   0,0,8'd0, 0,8'd0);

    step("multi_coin", 1,1,0, 0,0,0,   0,0,8'd0, 1,8'd0);
    step("rej_pulse",  0,0,0, 0,0,0,   0,0,8'd0, 0,8'd0);
    step("quarter2",   0,0,1, 0,0,0,   1,0,8'd0, 0,8'd10);
    step("coin_in_disp",0,0,1,0,0,0,   1,0,8'd0, 1,8'd10);
    step("cancel_disp",0,0,0, 1,0,0,   1,0,8'd0, 0,8'd10);
    step("vack2",      0,0,0, 0,1,0,   0,1,8'd10,0,8'd10);
    step("coin_in_ret",1,0,0, 1,0,0,   0,1,8'd10,1,8'd10);
    step("cack2",      0,0,0, 0,0,1,   0,0,8'd0, 0,8'd0);

    step("nickel5c",   1,0,0, 0,0,0,   0,0,8'd0, 0,8'd5);
    step("stray_acks", 0,0,0, 0,1,1,   0,0,8'd0, 0,8'd5);
    step("dime_eq",    0,1,0, 0,0,0,   1,0,8'd0, 0,8'd0);
    step("vack3",      0,0,0, 0,1,0,   0,0,8'd0, 0,8'd0);
    step("dime_q",     0,1,0, 0,0,0,   0,0,8'd0, 0,8'd10);
    step("quarter_hi", 0,0,1, 0,0,0,   1,0,8'd0, 0,8'd20);
    step("vack4",      0,0,0, 0,1,0,   0,1,8'd20,0,8'd20);
    step("cack4",      0,0,0, 0,0,1,   0,0,8'd0, 0,8'd0);

    step("quarter_rst",0,0,1, 0,0,0,   1,0,8'd0, 0,8'd10);
    #3 reset_n = 1'b0;
    #1;
    check_outs("async_rst", '{open: 0, cv: 0, amt: 0, rej: 0, credit: 0});
    #2 reset_n = 1'b1;
    step("dime_after", 0,1,0, 0,0,0,   0,0,8'd0, 0,8'd10);
    step("cancel_aft", 0,0,0, 1,0,0,   0,1,8'd10,0,8'd10);
    step("cack_aft",   0,0,0, 0,0,1,   0,0,8'd0, 0,8'd0);

`ifdef VEND_PRICE_PROG_EN
    price_write("pw30", 8'd30, 8'd0);
    step("p_quarter",  0,0,1, 0,0,0,   0,0,8'd0, 0,8'd25);
    step("p_nickel",   1,0,0, 0,0,0,   1,0,8'd0, 0,8'd0);
    step("p_vack",     0,0,0, 0,1,0,   0,0,8'd0, 0,8'd0);
    step("p_nickel5",  1,0,0, 0,0,0,   0,0,8'd0, 0,8'd5);
    price_write("pw_drop", 8'd10, 8'd5);
    step("p_dime",     0,1,0, 0,0,0,   0,0,8'd0, 0,8'd15);
    step("p_cancel",   0,0,0, 1,0,0,   0,1,8'd15,0,8'd15);
    step("p_cack",     0,0,0, 0,0,1,   0,0,8'd0, 0,8'd0);
    price_write("pw_zero", 8'd0, 8'd0);
    step("p_quarter2", 0,0,1, 0,0,0,   0,0,8'd0, 0,8'd25);
    step("p_nickel2",  1,0,0, 0,0,0,   1,0,8'd0, 0,8'd0);
    step("p_vack2",    0,0,0, 0,1,0,   0,0,8'd0, 0,8'd0);
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
